// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: latches one request,
// stalls the pipeline for LATENCY cycles, then commits the access in a single DONE cycle.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] Addr_i,
  input  logic [31:0] WriteData_i,
  output logic [31:0] ReadData_o,
  output logic        Stall_o,
  output logic        Done_o,
  output logic        AccessErr_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [3:0]      cnt_r;
  logic [AW+1:0]   addr_r;
  logic [31:0]     wdata_r;
  logic            wr_r;
  logic            err_r;
  logic [31:0]     rdata_r;
  logic [31:0]     mem_r [DEPTH_WORDS];

  logic            req_s;
  logic            commit_s;
  logic            c_wr_s;
  logic            c_mis_s;
  logic [AW+1:0]   c_addr_s;
  logic [31:0]     c_data_s;
  logic [AW-1:0]   c_word_s;
  logic            stall_s;
  logic            unused_addr_s;

  assign unused_addr_s = ^Addr_i[31:AW+2];

  // Commit selection: with a one-cycle latency the access commits straight from the inputs.
  always_comb begin
    req_s    = MemRead_i | MemWrite_i;
    commit_s = 1'b0;
    c_addr_s = addr_r;
    c_data_s = wdata_r;
    c_wr_s   = wr_r;
    case (state_r)
      IDLE: begin
        if ((LATENCY == 1) && req_s) begin
          commit_s = 1'b1;
          c_addr_s = Addr_i[AW+1:0];
          c_data_s = WriteData_i;
          c_wr_s   = MemWrite_i;
        end else begin
          commit_s = 1'b0;
        end
      end
      BUSY: begin
        if (cnt_r == 4'd0) begin
          commit_s = 1'b1;
        end else begin
          commit_s = 1'b0;
        end
      end
      default: commit_s = 1'b0;
    endcase
    c_mis_s  = |c_addr_s[1:0];
    c_word_s = c_addr_s[AW+1:2];
    stall_s  = rst_i & (((state_r == IDLE) & req_s) | (state_r == BUSY));
  end

  // Memory array write port; deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (rst_i && commit_s && c_wr_s && !c_mis_s) begin
      mem_r[c_word_s] <= c_data_s;
    end
  end

  // Request latch, sequencing FSM and read-data register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      addr_r  <= '0;
      wdata_r <= 32'd0;
      wr_r    <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_s) begin
            addr_r  <= Addr_i[AW+1:0];
            wdata_r <= WriteData_i;
            wr_r    <= MemWrite_i;
            cnt_r   <= CNT_INIT;
            state_r <= (LATENCY == 1) ? DONE : BUSY;
          end
        end
        BUSY: begin
          if (cnt_r == 4'd0) begin
            state_r <= DONE;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        DONE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
      if (commit_s) begin
        err_r <= c_mis_s;
        if (!c_wr_s) begin
          rdata_r <= c_mis_s ? 32'd0 : mem_r[c_word_s];
        end
      end
    end
  end

  assign ReadData_o  = rdata_r;
  assign Stall_o     = stall_s;
  assign Done_o      = (state_r == DONE);
  assign AccessErr_o = (state_r == DONE) & err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: two responders (LATENCY 3 / depth 256 and LATENCY 1 / depth 16)
// driven by directed and random requests against a word-array reference model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd, wr;
  logic [31:0] addr, wd;
  int          sel;

  logic [31:0] rdata3, rdata1;
  logic        st3, st1, dn3, dn1, er3, er1;
  logic [31:0] rdata_m;
  logic        st_m, dn_m, er_m;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem3 [int];
  logic [31:0] mem1 [int];
  logic [31:0] exp_rd [2];
  bit          rd_known [2];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) u3 (
    .clk_i(clk), .rst_i(rst),
    .MemRead_i(rd && (sel == 0)), .MemWrite_i(wr && (sel == 0)),
    .Addr_i(addr), .WriteData_i(wd),
    .ReadData_o(rdata3), .Stall_o(st3), .Done_o(dn3), .AccessErr_o(er3)
  );

  dmem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) u1 (
    .clk_i(clk), .rst_i(rst),
    .MemRead_i(rd && (sel == 1)), .MemWrite_i(wr && (sel == 1)),
    .Addr_i(addr), .WriteData_i(wd),
    .ReadData_o(rdata1), .Stall_o(st1), .Done_o(dn1), .AccessErr_o(er1)
  );

  assign rdata_m = (sel != 0) ? rdata1 : rdata3;
  assign st_m    = (sel != 0) ? st1 : st3;
  assign dn_m    = (sel != 0) ? dn1 : dn3;
  assign er_m    = (sel != 0) ? er1 : er3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_check();
    @(negedge clk);
    check("idle_stall", st_m, 1'b0);
    check("idle_done", dn_m, 1'b0);
    if (rd_known[sel]) check("idle_rdata_held", rdata_m, exp_rd[sel]);
    @(posedge clk); #1;
  endtask

  // One complete access: LATENCY stall cycles, then the DONE cycle.
  task automatic access(input int s, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d, input bit scramble);
    int  lat   = (s != 0) ? 1 : 3;
    int  depth = (s != 0) ? 16 : 256;
    int  widx  = int'((a >> 2) % 32'(depth));
    bit  mis   = (a[1:0] != 2'b00);
    sel = s; rd = r; wr = w; addr = a; wd = d;
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      check("stall_high", st_m, 1'b1);
      check("no_early_done", dn_m, 1'b0);
      @(posedge clk); #1;
      if (scramble) begin
        addr = $urandom; wd = $urandom;
        rd = 1'($urandom); wr = 1'($urandom);
      end
    end
    if (w) begin
      if (!mis) begin
        if (s != 0) mem1[widx] = d; else mem3[widx] = d;
      end
    end else if (mis) begin
      exp_rd[s] = 32'd0; rd_known[s] = 1'b1;
    end else if ((s != 0) ? mem1.exists(widx) : mem3.exists(widx)) begin
      exp_rd[s] = (s != 0) ? mem1[widx] : mem3[widx]; rd_known[s] = 1'b1;
    end else begin
      rd_known[s] = 1'b0;
    end
    @(negedge clk);
    check("done_stall_low", st_m, 1'b0);
    check("done_pulse", dn_m, 1'b1);
    check("access_err", er_m, 1'(mis));
    if (rd_known[s]) check("done_rdata", rdata_m, exp_rd[s]);
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
  endtask

  initial begin
    rst = 1'b0; rd = 1'b1; wr = 1'b0; addr = 32'h10; wd = 32'd0; sel = 0;
    exp_rd[0] = 32'd0; exp_rd[1] = 32'd0; rd_known[0] = 1'b1; rd_known[1] = 1'b1;
    #2;
    check("rst_stall", st3, 1'b0);
    check("rst_done", dn3, 1'b0);
    check("rst_err", er3, 1'b0);
    check("rst_rdata", rdata3, 32'd0);
    check("rst_rdata_l1", rdata1, 32'd0);
    @(negedge clk); rd = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    idle_check();

    // Write then read with LATENCY 3
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    idle_check();
    idle_check();

    // Back-to-back with LATENCY 1, plus aliasing in the 16-word array
    access(1, 1'b0, 1'b1, 32'h4, 32'h1, 1'b0);
    access(1, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
    idle_check();
    access(1, 1'b0, 1'b1, 32'h4 + 32'd64, 32'h0000_0BAD, 1'b0);
    access(1, 1'b1, 1'b0, 32'hFFFF_0004, 32'h0, 1'b0);

    // Misaligned write then read
    access(0, 1'b0, 1'b1, 32'h13, 32'h55, 1'b0);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    access(0, 1'b1, 1'b0, 32'h11, 32'h0, 1'b0);

    // Reset in the second stall cycle of a write
    access(0, 1'b0, 1'b1, 32'h20, 32'h1234_5678, 1'b0);
    sel = 0; wr = 1'b1; addr = 32'h20; wd = 32'hCAFE;
    @(negedge clk);
    check("pre_rst_stall", st3, 1'b1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("midrst_stall", st3, 1'b0);
    check("midrst_done", dn3, 1'b0);
    check("midrst_rdata", rdata3, 32'd0);
    @(posedge clk); #1;
    check("midrst_no_done", dn3, 1'b0);
    @(negedge clk); wr = 1'b0; rst = 1'b1;
    exp_rd[0] = 32'd0; exp_rd[1] = 32'd0; rd_known[0] = 1'b1; rd_known[1] = 1'b1;
    @(posedge clk); #1;
    idle_check();
    access(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);

    // Read and write together: treated as a write, read data unchanged
    access(0, 1'b1, 1'b1, 32'h30, 32'hA5A5_5A5A, 1'b0);
    access(0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b0);

    // Inputs scrambled while busy: latched request must win
    access(0, 1'b0, 1'b1, 32'h40, 32'h77, 1'b1);
    access(0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1);

    // Random traffic on both instances
    for (int i = 0; i < 60; i++) begin
      int          s;
      logic        r, w;
      logic [31:0] a;
      s = int'($urandom_range(0, 1));
      w = 1'($urandom);
      r = w ? 1'($urandom) : 1'b1;
      a = ($urandom & 32'hFFFF_FFFC) | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
      access(s, r, w, a, $urandom, 1'($urandom));
      if ($urandom_range(0, 2) == 0) idle_check();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder for the MEM stage of the five-stage pipeline. It accepts read/write requests carried by the EX/MEM pipeline register and serves them from a word-addressed array after a fixed access latency. While an access is outstanding it asserts a stall to freeze the upstream pipeline registers. It delivers read data to the MEM/WB register on the cycle the access completes.

## Interface

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words; power of two, 4..4096.
- LATENCY, 3: stall cycles per access; legal range 1..15.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset; one clock, asynchronous, active-low.
- MemRead_i  input  1  read request from EX/MEM.
- MemWrite_i  input  1  write request from EX/MEM.
- Addr_i  input  32  byte address (ALU result).
- WriteData_i  input  32  store data.
- ReadData_o  output  32  registered read data to MEM/WB.
- Stall_o  output  1  high while the access is outstanding; freezes PC, IF/ID, ID/EX and EX/MEM.
- Done_o  output  1  one-cycle pulse; the access completes this cycle.
- AccessErr_o  output  1  one-cycle pulse, coincident with Done_o, for a misaligned access.

## Operation

- FSM states: IDLE, BUSY, DONE. The 4-bit down-counter cnt is used only in BUSY.
- IDLE, no request: Stall_o=0 and the state stays IDLE.
- IDLE, MemRead_i or MemWrite_i high:
  - Stall_o=1 combinationally in the same cycle.
  - Addr_i, WriteData_i and op are latched at the edge; op is write if MemWrite_i is high, else read.
  - If LATENCY==1, next state is DONE. Otherwise next state is BUSY with cnt=LATENCY-2.
- BUSY:
  - Stall_o=1.
  - If cnt==0, next state is DONE; otherwise cnt decrements.
  - Input changes during BUSY are ignored; the latched request is authoritative.
- On the edge entering DONE, the access commits:
  - Write: mem[word] <= latched data.
  - Read: ReadData_o <= mem[word].
- DONE:
  - Stall_o=0, Done_o=1, and the pipeline advances at this edge.
  - Inputs are ignored because they still carry the completed request.
  - Next state is always IDLE.
- Addressing: word = latched Addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses alias.
- Misaligned access (Addr[1:0]!=0):
  - Write is suppressed.
  - Read loads ReadData_o=0.
  - AccessErr_o=1 in DONE.
- Simultaneous MemRead_i and MemWrite_i: treated as a write; ReadData_o is unchanged.
- ReadData_o holds its value until the next completed read; writes never modify it.

## Timing

- Reset values while rst_i=0, applied immediately: state=IDLE, cnt=0, ReadData_o=0, Stall_o=0, Done_o=0, AccessErr_o=0, latched request registers=0.
- The memory array is not reset; its contents are undefined until written.
- Reset asserted mid-access abandons the access: no write is committed and ReadData_o is forced to 0.
- A request first seen at cycle t:
  - Stall_o is high for exactly LATENCY cycles, t..t+LATENCY-1.
  - DONE occurs at cycle t+LATENCY.
  - Total occupancy is LATENCY+1 cycles.
- Back-to-back requests: a new request can be accepted in the IDLE cycle immediately after DONE (t+LATENCY+1).
- The minimum spacing between completions is therefore LATENCY+1 cycles.
- Stall_o is a combinational function of state and request inputs. Done_o and AccessErr_o are decoded from state and registered flags only.

## Test plan

- Reset: drive rst_i=0 mid-simulation.
  - Required: all outputs 0 within the same cycle.
  - Required after release: state IDLE and Stall_o=0 with no request applied.
- Write then read, LATENCY=3:
  - Stimulus: write 0xDEADBEEF to 0x00000010.
  - Required: Stall_o high for 3 cycles, then Done_o for 1 cycle.
  - Stimulus: read 0x00000010.
  - Required: ReadData_o=0xDEADBEEF in its DONE cycle, held afterwards.
- Back-to-back with LATENCY=1:
  - Stimulus: write 0x1 to 0x4, read 0x4 in the next IDLE cycle.
  - Required: stall pattern 1,0,1,0; ReadData_o=0x00000001.
- Misaligned write:
  - Stimulus: write 0x55 to 0x13.
  - Required: AccessErr_o=1 with Done_o.
  - Required: a subsequent read of 0x10 returns the prior contents.
  - Stimulus: misaligned read.
  - Required: ReadData_o=0.
- Reset during BUSY:
  - Stimulus: assert rst_i in the second stall cycle of a write of 0xCAFE to 0x20.
  - Required: Stall_o=0 immediately and no Done_o.
  - Required: a later read of 0x20 returns the pre-test value.
- Read+write together; inputs changed mid-BUSY:
  - Stimulus: both MemRead_i and MemWrite_i high.
  - Required: the write commits and ReadData_o is unchanged.
  - Stimulus: change Addr_i during BUSY.
  - Required: the originally latched address is used.
